// File: rtl/pipe_dbg_pkg.sv
// pipe_dbg_pkg: mode encodings and controller state type shared by the pipeline debug controller
package pipe_dbg_pkg;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_HALT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        BURST = 2'd2
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, stable-count debouncer and registered rising-edge pulse
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d, db_prev_q, rise_q;
    logic          key_s, differ, hit;

    assign key_s  = sync_q[1];
    assign differ = key_s != db_q;
    // the new level is taken once the mismatch has lasted DEB_CYCLES consecutive cycles
    assign hit    = differ && cnt_q == CW'(DEB_CYCLES - 1);

    always_comb begin
        cnt_d = (!differ || hit) ? '0 : cnt_q + 1'b1;
        db_d  = hit ? key_s : db_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_raw};
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            rise_q    <= db_q && !db_prev_q;
        end
    end

    assign key_level = db_q;
    assign key_rise  = rise_q;

endmodule

// File: rtl/pipeline_step_ctrl.sv
// pipeline_step_ctrl: run/step/burst/halt clock-enable generator for the pipeline,
// driven by a debounced push-button, with a wrapping count of enabled cycles
module pipeline_step_ctrl
    import pipe_dbg_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int BURST_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_en,
    output logic               key_pulse,
    output logic               busy,
    output logic [CNT_W-1:0]   cycle_cnt
);
    state_e             state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               en_q, en_d, busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               key_level_unused;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key),
        .key_level(key_level_unused),
        .key_rise (key_pulse)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (key_pulse && mode == MODE_STEP) state_d = STEP;
                if (key_pulse && mode == MODE_BURST) begin
                    state_d = BURST;
                    rem_d   = (burst_len == '0) ? BURST_W'(1) : burst_len;
                end
            end
            STEP: state_d = IDLE;
            BURST: begin
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == BURST_W'(1) || mode != MODE_BURST) ? IDLE : BURST;
            end
            default: state_d = IDLE;
        endcase
        // enable is registered from the next state so STEP/BURST cycles line up with cpu_en
        en_d   = (mode == MODE_RUN) || (mode != MODE_HALT && state_d != IDLE);
        busy_d = state_d == BURST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_q + CNT_W'(en_q);
        end
    end

    assign cpu_en    = en_q;
    assign busy      = busy_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// tb_pipeline_step_ctrl: scenario tasks with a run-length scoreboard for the step controller
module tb_pipeline_step_ctrl;
    import pipe_dbg_pkg::*;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key = 1'b0;
    logic [1:0]  mode = MODE_RUN;
    logic [7:0]  burst_len = 8'd1;
    logic        cpu_en, key_pulse, busy;
    logic [15:0] cycle_cnt;
    logic        cpu_en_w, key_pulse_w, busy_w;
    logic [3:0]  cnt_w;

    int checks = 0;
    int errors = 0;
    int pulse_n = 0;
    int busy_n = 0;
    int en_n = 0;
    int run = 0;
    int obs_runs[$];
    int exp_q[$];

    always #5 clk = ~clk;

    pipeline_step_ctrl #(.DEB_CYCLES(DEB), .BURST_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .key(key), .mode(mode), .burst_len(burst_len),
        .cpu_en(cpu_en), .key_pulse(key_pulse), .busy(busy), .cycle_cnt(cycle_cnt)
    );

    pipeline_step_ctrl #(.DEB_CYCLES(DEB), .BURST_W(8), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .key(key), .mode(mode), .burst_len(burst_len),
        .cpu_en(cpu_en_w), .key_pulse(key_pulse_w), .busy(busy_w), .cycle_cnt(cnt_w)
    );

    // observed side of the scoreboard: lengths of each contiguous cpu_en run
    always @(negedge clk) begin
        pulse_n <= pulse_n + int'(key_pulse);
        busy_n  <= busy_n + int'(busy);
        en_n    <= en_n + int'(cpu_en);
        if (cpu_en) run <= run + 1;
        else if (run > 0) begin
            obs_runs.push_back(run);
            run <= 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset = 1'b1;
        key   = 1'b0;
        mode  = m;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int p0;
        mode  = MODE_RUN;
        key   = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cpu_en !== 1'b0 || cycle_cnt !== 16'd0 || busy !== 1'b0 || key_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: cpu_en=%b cnt=%0d busy=%b pulse=%b, required 0 0 0 0",
                         cpu_en, cycle_cnt, busy, key_pulse);
            end
        end
        p0 = pulse_n;
        reset = 1'b0;
        tick();
        checks++;
        if (cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_run_en: cpu_en=%b, required 1", cpu_en);
        end
        repeat (10) tick();
        checks++;
        if (cycle_cnt !== 16'd10) begin
            errors++;
            $display("FAIL reset_run_cnt: cycle_cnt=%0d, required 10", cycle_cnt);
        end
        checks++;
        if (pulse_n - p0 !== 1) begin
            errors++;
            $display("FAIL run_key_pulse: pulses=%0d, required 1", pulse_n - p0);
        end
        key = 1'b0;
    endtask

    task automatic test_bounce();
        int base, p0, lat, e, o;
        logic [15:0] c0;
        do_reset(MODE_STEP);
        base = obs_runs.size();
        c0 = cycle_cnt;
        p0 = pulse_n;
        for (int i = 0; i < 4; i++) begin
            key = (i % 2 == 0);
            tick();
        end
        key = 1'b1;
        tick();
        lat = 0;
        while (key_pulse !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        exp_q.push_back(1);
        checks++;
        if (lat !== DEB + 2) begin
            errors++;
            $display("FAIL bounce_latency: %0d cycles, required %0d", lat, DEB + 2);
        end
        tick();
        checks++;
        if (cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL step_en_after_pulse: cpu_en=%b, required 1", cpu_en);
        end
        repeat (8) tick();
        key = 1'b0;
        repeat (12) tick();
        checks++;
        if (pulse_n - p0 !== 1) begin
            errors++;
            $display("FAIL bounce_pulses: %0d, required 1", pulse_n - p0);
        end
        checks++;
        if (cycle_cnt !== 16'(c0 + 1)) begin
            errors++;
            $display("FAIL step_cnt: %0d, required %0d", cycle_cnt, 16'(c0 + 1));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (base < obs_runs.size()) ? obs_runs[base] : -1;
            base++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL step_run: length %0d, required %0d", o, e);
            end
        end
        checks++;
        if (obs_runs.size() != base) begin
            errors++;
            $display("FAIL step_runs_total: %0d runs, required %0d", obs_runs.size(), base);
        end
    endtask

    task automatic test_burst();
        int base, p0, b0, e, o;
        logic [15:0] c0;
        do_reset(MODE_BURST);
        base = obs_runs.size();
        c0 = cycle_cnt;
        p0 = pulse_n;
        b0 = busy_n;
        burst_len = 8'd5;
        exp_q.push_back(5);
        key = 1'b1;
        repeat (8) tick();
        key = 1'b0;
        repeat (20) tick();
        checks++;
        if (busy_n - b0 !== 5) begin
            errors++;
            $display("FAIL burst_busy: %0d busy cycles, required 5", busy_n - b0);
        end
        checks++;
        if (cycle_cnt !== 16'(c0 + 5)) begin
            errors++;
            $display("FAIL burst_cnt: %0d, required %0d", cycle_cnt, 16'(c0 + 5));
        end
        // second press lands mid-burst and must be dropped; burst_len change must not matter
        burst_len = 8'd16;
        exp_q.push_back(16);
        key = 1'b1;
        repeat (5) tick();
        key = 1'b0;
        repeat (6) tick();
        burst_len = 8'd3;
        key = 1'b1;
        repeat (8) tick();
        key = 1'b0;
        repeat (25) tick();
        checks++;
        if (pulse_n - p0 !== 3) begin
            errors++;
            $display("FAIL burst_pulses: %0d, required 3", pulse_n - p0);
        end
        checks++;
        if (cycle_cnt !== 16'(c0 + 21)) begin
            errors++;
            $display("FAIL burst_ignore_cnt: %0d, required %0d", cycle_cnt, 16'(c0 + 21));
        end
        burst_len = 8'd0;
        exp_q.push_back(1);
        key = 1'b1;
        repeat (8) tick();
        key = 1'b0;
        repeat (15) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (base < obs_runs.size()) ? obs_runs[base] : -1;
            base++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL burst_run: length %0d, required %0d", o, e);
            end
        end
        checks++;
        if (obs_runs.size() != base) begin
            errors++;
            $display("FAIL burst_runs_total: %0d runs, required %0d", obs_runs.size(), base);
        end
    endtask

    task automatic test_abort();
        int base, w, e, o;
        do_reset(MODE_BURST);
        base = obs_runs.size();
        burst_len = 8'd200;
        key = 1'b1;
        w = 0;
        while (cpu_en !== 1'b1 && w < 30) begin
            tick();
            w++;
        end
        key = 1'b0;
        repeat (6) tick();
        exp_q.push_back(7);
        mode = MODE_HALT;
        tick();
        checks++;
        if (cpu_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: cpu_en=%b busy=%b, required 0 0", cpu_en, busy);
        end
        checks++;
        if (cycle_cnt !== 16'd7) begin
            errors++;
            $display("FAIL abort_cnt: %0d, required 7", cycle_cnt);
        end
        repeat (3) tick();
        checks++;
        if (cycle_cnt !== 16'd7 || cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: cnt=%0d cpu_en=%b, required 7 0", cycle_cnt, cpu_en);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (base < obs_runs.size()) ? obs_runs[base] : -1;
            base++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_run: length %0d, required %0d", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] e4;
        do_reset(MODE_RUN);
        tick();
        checks++;
        if (cpu_en_w !== 1'b1 || cnt_w !== 4'd0) begin
            errors++;
            $display("FAIL wrap_start: cpu_en=%b cnt=%0d, required 1 0", cpu_en_w, cnt_w);
        end
        for (int i = 0; i < 17; i++) begin
            tick();
            e4 = 4'(i + 1);
            checks++;
            if (cnt_w !== e4 || cycle_cnt !== 16'(i + 1)) begin
                errors++;
                $display("FAIL wrap_cnt[%0d]: narrow=%0d wide=%0d, required %0d %0d",
                         i, cnt_w, cycle_cnt, e4, i + 1);
            end
        end
    endtask

    task automatic test_halt();
        int base, p0, e0;
        logic [15:0] c0;
        do_reset(MODE_HALT);
        base = obs_runs.size();
        c0 = cycle_cnt;
        p0 = pulse_n;
        e0 = en_n;
        for (int i = 0; i < 3; i++) begin
            key = 1'b1;
            repeat (8) tick();
            key = 1'b0;
            repeat (8) tick();
        end
        checks++;
        if (pulse_n - p0 !== 3) begin
            errors++;
            $display("FAIL halt_pulses: %0d, required 3", pulse_n - p0);
        end
        checks++;
        if (en_n - e0 !== 0 || obs_runs.size() != base) begin
            errors++;
            $display("FAIL halt_en: %0d enabled cycles, required 0", en_n - e0);
        end
        checks++;
        if (cycle_cnt !== c0) begin
            errors++;
            $display("FAIL halt_cnt: %0d, required %0d", cycle_cnt, c0);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_burst();
        test_abort();
        test_wrap();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
